// File: rtl/id_ex_reg_if.sv
// Decode-to-execute pipeline register bus: D-stage fields in, E-stage fields out,
// plus the hazard unit's stall/flush controls.
interface id_ex_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic                      StallE, FlushE, ValidD;
  logic [DATA_WIDTH-1:0]     RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, RdD;
  logic                      RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]                ResultSrcD;
  logic [2:0]                ALUControlD;

  logic                      ValidE;
  logic [DATA_WIDTH-1:0]     RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [REG_ADDR_WIDTH-1:0] Rs1E, Rs2E, RdE;
  logic                      RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]                ResultSrcE;
  logic [2:0]                ALUControlE;
  logic [CNT_WIDTH-1:0]      BubbleCountE;

  modport master (
    output StallE, FlushE, ValidD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD,
    input  ValidE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, BubbleCountE
  );

  modport slave (
    input  StallE, FlushE, ValidD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD,
    output ValidE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, BubbleCountE
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: flush > stall > load, invalid decode becomes an
// all-zero bubble, and a saturating count of inserted bubbles.
module id_ex_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_reg_if.slave   bus
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rd1, rd2, pc, pc_plus4, imm;
    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic                      reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]                result_src;
    logic [2:0]                alu_ctrl;
  } ex_t;

  ex_t                  q, d;
  logic [CNT_WIDTH-1:0] bubbles, bubbles_inc;

  // An invalid decode is loaded as the all-zero bubble so no write-enable or
  // index can leak into forwarding/hazard logic.
  always_comb begin
    d = '0;
    if (bus.ValidD) begin
      d.valid      = 1'b1;
      d.rd1        = bus.RD1D;
      d.rd2        = bus.RD2D;
      d.pc         = bus.PCD;
      d.pc_plus4   = bus.PCPlus4D;
      d.imm        = bus.ImmExtD;
      d.rs1        = bus.Rs1D;
      d.rs2        = bus.Rs2D;
      d.rd         = bus.RdD;
      d.reg_write  = bus.RegWriteD;
      d.mem_write  = bus.MemWriteD;
      d.jump       = bus.JumpD;
      d.branch     = bus.BranchD;
      d.alu_src    = bus.ALUSrcD;
      d.result_src = bus.ResultSrcD;
      d.alu_ctrl   = bus.ALUControlD;
    end
  end

  assign bubbles_inc = (bubbles == {CNT_WIDTH{1'b1}}) ? bubbles : bubbles + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      bubbles <= '0;
    end else if (bus.FlushE) begin
      q       <= '0;
      bubbles <= bubbles_inc;
    end else if (!bus.StallE) begin
      q <= d;
      if (!bus.ValidD) bubbles <= bubbles_inc;
    end
  end

  assign bus.ValidE       = q.valid;
  assign bus.RD1E         = q.rd1;
  assign bus.RD2E         = q.rd2;
  assign bus.PCE          = q.pc;
  assign bus.PCPlus4E     = q.pc_plus4;
  assign bus.ImmExtE      = q.imm;
  assign bus.Rs1E         = q.rs1;
  assign bus.Rs2E         = q.rs2;
  assign bus.RdE          = q.rd;
  assign bus.RegWriteE    = q.reg_write;
  assign bus.MemWriteE    = q.mem_write;
  assign bus.JumpE        = q.jump;
  assign bus.BranchE      = q.branch;
  assign bus.ALUSrcE      = q.alu_src;
  assign bus.ResultSrcE   = q.result_src;
  assign bus.ALUControlE  = q.alu_ctrl;
  assign bus.BubbleCountE = bubbles;

  bubble_clean: assert property (@(posedge clk) disable iff (rst)
    !q.valid |-> (!q.reg_write && !q.mem_write && !q.jump && !q.branch && q.rd == '0));

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: expected E-stage contents are queued as each
// D-stage step is driven and popped/compared one edge later.
module tb_id_ex_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_reg_if                   bus ();
  id_ex_reg_if #(.CNT_WIDTH(4))  sbus ();

  id_ex_reg                  u_dut (.clk(clk), .rst(rst), .bus(bus));
  id_ex_reg #(.CNT_WIDTH(4)) u_sat (.clk(clk), .rst(rst), .bus(sbus));

  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regw, memw, jump, branch, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    logic [15:0] cnt;
  } ent_t;

  ent_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t cur, d, e;

  function automatic ent_t bubble(logic [15:0] c);
    ent_t b;
    b = '{valid: 1'b0, rd1: '0, rd2: '0, pc: '0, pc4: '0, imm: '0, rs1: '0, rs2: '0,
          rd: '0, regw: 1'b0, memw: 1'b0, jump: 1'b0, branch: 1'b0, alusrc: 1'b0,
          rsrc: '0, alu: '0, cnt: c};
    return b;
  endfunction

  function automatic ent_t mk(logic v, logic [31:0] r1, logic [4:0] rd, logic rw,
                              logic mw, logic [2:0] alu);
    ent_t m;
    m = bubble(16'd0);
    m.valid = v;  m.rd1 = r1;  m.rd2 = ~r1;  m.pc = r1 + 32'h100;
    m.pc4 = r1 + 32'h104;  m.imm = {r1[15:0], r1[31:16]};
    m.rs1 = rd + 5'd1;  m.rs2 = rd + 5'd2;  m.rd = rd;
    m.regw = rw;  m.memw = mw;  m.alu = alu;
    return m;
  endfunction

  function automatic ent_t loaded(ent_t s, logic [15:0] c);
    ent_t r;
    r = s;
    r.cnt = c;
    return r;
  endfunction

  task automatic drive(ent_t s, logic stall, logic flush);
    bus.StallE = stall;     bus.FlushE = flush;     bus.ValidD = s.valid;
    bus.RD1D = s.rd1;       bus.RD2D = s.rd2;       bus.PCD = s.pc;
    bus.PCPlus4D = s.pc4;   bus.ImmExtD = s.imm;
    bus.Rs1D = s.rs1;       bus.Rs2D = s.rs2;       bus.RdD = s.rd;
    bus.RegWriteD = s.regw; bus.MemWriteD = s.memw; bus.JumpD = s.jump;
    bus.BranchD = s.branch; bus.ALUSrcD = s.alusrc; bus.ResultSrcD = s.rsrc;
    bus.ALUControlD = s.alu;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cmp_all(string tag, ent_t x);
    chk({tag, ".ValidE"},   32'(bus.ValidE),      32'(x.valid));
    chk({tag, ".RD1E"},     bus.RD1E,             x.rd1);
    chk({tag, ".RD2E"},     bus.RD2E,             x.rd2);
    chk({tag, ".PCE"},      bus.PCE,              x.pc);
    chk({tag, ".PCPlus4E"}, bus.PCPlus4E,         x.pc4);
    chk({tag, ".ImmExtE"},  bus.ImmExtE,          x.imm);
    chk({tag, ".Rs1E"},     32'(bus.Rs1E),        32'(x.rs1));
    chk({tag, ".Rs2E"},     32'(bus.Rs2E),        32'(x.rs2));
    chk({tag, ".RdE"},      32'(bus.RdE),         32'(x.rd));
    chk({tag, ".RegWrE"},   32'(bus.RegWriteE),   32'(x.regw));
    chk({tag, ".MemWrE"},   32'(bus.MemWriteE),   32'(x.memw));
    chk({tag, ".JumpE"},    32'(bus.JumpE),       32'(x.jump));
    chk({tag, ".BranchE"},  32'(bus.BranchE),     32'(x.branch));
    chk({tag, ".ALUSrcE"},  32'(bus.ALUSrcE),     32'(x.alusrc));
    chk({tag, ".ResSrcE"},  32'(bus.ResultSrcE),  32'(x.rsrc));
    chk({tag, ".ALUCtlE"},  32'(bus.ALUControlE), 32'(x.alu));
    chk({tag, ".BubCnt"},   32'(bus.BubbleCountE), 32'(x.cnt));
  endtask

  // One edge: pop the entry queued for this edge and compare after it settles.
  task automatic tick(string tag);
    @(posedge clk);
    #1;
    n_cmp++;
    assert (sbq.size() != 0) else begin
      n_err++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      cmp_all(tag, e);
    end
    @(negedge clk);
  endtask

  initial begin
    // Saturation instance stays stalled until its own phase.
    sbus.StallE = 1'b1;  sbus.FlushE = 1'b0;  sbus.ValidD = 1'b0;
    sbus.RD1D = '0;  sbus.RD2D = '0;  sbus.PCD = '0;  sbus.PCPlus4D = '0;
    sbus.ImmExtD = '0;  sbus.Rs1D = '0;  sbus.Rs2D = '0;  sbus.RdD = '0;
    sbus.RegWriteD = 1'b0;  sbus.MemWriteD = 1'b0;  sbus.JumpD = 1'b0;
    sbus.BranchD = 1'b0;  sbus.ALUSrcD = 1'b0;  sbus.ResultSrcD = '0;
    sbus.ALUControlD = '0;

    d = mk(1'b1, 32'hDEADBEEF, 5'd3, 1'b1, 1'b0, 3'b001);
    drive(d, 1'b0, 1'b0);
    #3 cmp_all("reset", bubble(16'd0));
    @(negedge clk) rst = 1'b0;

    sbq.push_back(loaded(d, 16'd0));
    tick("load_deadbeef");
    #2 rst = 1'b1;
    #1 cmp_all("rst_async", bubble(16'd0));
    @(posedge clk); #1 cmp_all("rst_hold", bubble(16'd0));
    @(negedge clk) rst = 1'b0;

    cur = mk(1'b1, 32'h12345678, 5'd5, 1'b1, 1'b0, 3'b010);
    drive(cur, 1'b0, 1'b0);
    sbq.push_back(loaded(cur, 16'd0));
    tick("normal_load");

    d = mk(1'b1, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0, 3'b110);
    drive(d, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(loaded(cur, 16'd0));
      tick("stall");
    end
    drive(d, 1'b0, 1'b0);
    sbq.push_back(loaded(d, 16'd0));
    tick("stall_release");

    drive(mk(1'b1, 32'h0BADF00D, 5'd7, 1'b1, 1'b0, 3'b011), 1'b1, 1'b1);
    sbq.push_back(bubble(16'd1));
    tick("flush_over_stall");

    drive(mk(1'b0, 32'hAAAA5555, 5'd9, 1'b1, 1'b1, 3'b111), 1'b0, 1'b0);
    sbq.push_back(bubble(16'd2));
    tick("invalid_decode");

    drive(mk(1'b0, 32'h13579BDF, 5'd4, 1'b1, 1'b0, 3'b000), 1'b1, 1'b0);
    sbq.push_back(bubble(16'd2));
    tick("stall_holds_count");

    d = mk(1'b1, 32'h80000001, 5'd31, 1'b1, 1'b0, 3'b101);
    d.jump = 1'b1;  d.rsrc = 2'b10;  d.alusrc = 1'b1;
    drive(d, 1'b0, 1'b0);
    sbq.push_back(loaded(d, 16'd2));
    tick("load_jump");

    d = mk(1'b1, 32'h00000040, 5'd0, 1'b0, 1'b1, 3'b001);
    d.branch = 1'b1;  d.rsrc = 2'b01;
    drive(d, 1'b0, 1'b0);
    sbq.push_back(loaded(d, 16'd2));
    tick("load_branch_store");

    // Reset during a stall clears everything, count included.
    drive(mk(1'b1, 32'h55AA55AA, 5'd12, 1'b1, 1'b0, 3'b100), 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 cmp_all("rst_mid_stall", bubble(16'd0));
    @(negedge clk) rst = 1'b0;
    d = mk(1'b1, 32'h55AA55AA, 5'd12, 1'b1, 1'b0, 3'b100);
    drive(d, 1'b0, 1'b0);
    sbq.push_back(loaded(d, 16'd0));
    tick("load_after_rst");

    sbus.FlushE = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1 chk($sformatf("sat_flush%0d", i), 32'(sbus.BubbleCountE), (i > 15) ? 32'd15 : 32'(i));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
